ab_feed_scheduler: RTL
======================

// Module: ab_feed_scheduler
// PURPOSE
//  Sequences operand fetch for the linear PE chain: shares one in-order memory read port between the A-feed and B-feed FIFOs at the chain head.
//  Per tile: A block (cfg_a_len words) then B stream (cfg_b_len words); A of tile t+1 is prefetched while B of tile t streams, matching the PE ping-pong A buffer.
//  Start/busy/done handshake toward the host controller; routes in-order responses to the correct FIFO via a tag queue.
// PARAMETERS
//  D_WIDTH     64  data word width
//  ADDR_W      32  word address width
//  LEN_W       16  width of per-tile A/B length fields
//  TILE_W      16  width of tile count
//  OUTST_MAX   8   max outstanding reads (power of 2)
// PORTS
//  clk            in   1        clock
//  rst            in   1        async active-high reset
//  start          in   1        1-cycle pulse; latches cfg_* when idle
//  cfg_a_base     in   ADDR_W   first A word address; A pointer runs contiguously across tiles
//  cfg_b_base     in   ADDR_W   B base; B pointer restarts here every tile
//  cfg_a_len      in   LEN_W    A words per tile
//  cfg_b_len      in   LEN_W    B words per tile
//  cfg_tiles      in   TILE_W   tile count
//  busy           out  1        high from start acceptance to done
//  done           out  1        1-cycle pulse at job completion
//  mem_req_valid  out  1        read request valid
//  mem_req_ready  in   1        read request accepted when valid&ready
//  mem_req_addr   out  ADDR_W   request word address
//  mem_rsp_valid  in   1        in-order read data valid
//  mem_rsp_data   in   D_WIDTH  read data
//  a_fifo_wr_en   out  1        push to A-feed FIFO
//  a_fifo_data    out  D_WIDTH  A push data
//  a_fifo_afull   in   1        A FIFO almost full (>= OUTST_MAX free slots when low)
//  b_fifo_wr_en   out  1        push to B-feed FIFO
//  b_fifo_data    out  D_WIDTH  B push data
//  b_fifo_afull   in   1        B FIFO almost full
//  err_orphan     out  1        sticky: response arrived with empty tag queue; cleared by start
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; pointers, counters and tag queue cleared. A reset mid-job abandons the job; no done pulse.
//  FSM: IDLE -start-> RUN -all requests issued-> DRAIN -outstanding==0 and last push done-> DONE (1 cycle, done=1) -> IDLE.
//  start while busy: ignored. Any of cfg_tiles/a_len/b_len == 0: IDLE->DONE, no requests, done 2 cycles after start.
//  Latency: start in cycle 0 -> busy=1 and mem_req_valid may first assert in cycle 1.
//  Eligibility:
//   A eligible: a_tile <= b_tile+1 (prefetch at most one tile ahead), a_tile < cfg_tiles, !a_fifo_afull, outstanding < OUTST_MAX.
//   B eligible: A for that tile fully issued, b_tile < cfg_tiles, !b_fifo_afull, outstanding < OUTST_MAX.
//  Arbitration: round-robin between A and B when both eligible; the last granted stream loses the next tie. Grant is held stable while valid&!ready (AXI-style: addr/stream must not change).
//  Each accept pushes sel bit (0=A, 1=B) into tag queue, and the stream pointer/count increments.
//  Count wrap advances the stream's tile counter; the B pointer reloads cfg_b_base.
//  Response: rsp_valid pops tag; registered push, so wr_en+data appear 1 cycle after rsp_valid. Same-cycle accept and response: count unchanged.
//  Empty tag queue on rsp_valid: data dropped, err_orphan=1.
//  Outstanding counter never exceeds OUTST_MAX; address arithmetic wraps modulo 2^ADDR_W.
// CONFIGURATION
//  AB_FEED_PERF_EN defined:
//   adds outputs perf_busy_cyc[31:0] (cycles busy=1) and perf_stall_cyc[31:0] (cycles busy, RUN, no stream eligible).
//   Both counters saturate at all-ones and clear on start.
//  Not defined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  Package ab_feed_pkg: fsm state enum (IDLE, RUN, DRAIN, DONE); stream_sel_e (SEL_A=0, SEL_B=1).
//  Sub-module ab_tag_fifo: OUTST_MAX-deep 1-bit sync FIFO with count, async reset.
// TESTING
//  1. tiles=2, a_len=4, b_len=3, ready=1, 1-cycle rsp -> A addrs base..+3 then B b_base..+2, A tile1 (+4..+7) interleaved with B; 8 A pushes, 6 B pushes; done once.
//  2. cfg_tiles=0 -> no mem_req_valid, done pulse exactly cycle 2, busy high cycles 1-2.
//  3. b_fifo_afull held high -> only A tile0 and tile1 issued, then A stalls on prefetch limit; release -> job completes correctly.
//  4. mem_req_ready low 5 cycles with valid high -> addr stable; outstanding caps at 8 with rsp withheld.
//  5. rst asserted mid-RUN -> all outputs 0 next edge, no done; new start runs clean.
//  6. rsp_valid while idle -> err_orphan=1, no FIFO push; next start clears it.

Source files
------------

// File: rtl/ab_feed_pkg.sv
// Shared types for the A/B operand-feed scheduler: FSM states and stream select.
package ab_feed_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fsm_state_e;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } stream_sel_e;
endpackage

// File: rtl/ab_tag_fifo.sv
// 1-bit tag FIFO recording which stream owns each outstanding read; the count
// doubles as the outstanding-request counter.
module ab_tag_fifo #(
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_din,
   input  logic          i_pop,
   output logic          o_dout,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);
   logic [DEPTH-1:0] r_mem;
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
endmodule

// File: rtl/ab_feed_scheduler.sv
// Shares one in-order read port between the A-feed and B-feed FIFOs, prefetching
// A of tile t+1 while B of tile t streams. Optional AB_FEED_PERF_EN adds perf counters.
module ab_feed_scheduler
   import ab_feed_pkg::*;
#(
   parameter int D_WIDTH   = 64,
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 16,
   parameter int TILE_W    = 16,
   parameter int OUTST_MAX = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  cfg_a_base,
   input  logic [ADDR_W-1:0]  cfg_b_base,
   input  logic [LEN_W-1:0]   cfg_a_len,
   input  logic [LEN_W-1:0]   cfg_b_len,
   input  logic [TILE_W-1:0]  cfg_tiles,
   output logic               busy,
   output logic               done,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [ADDR_W-1:0]  mem_req_addr,
   input  logic               mem_rsp_valid,
   input  logic [D_WIDTH-1:0] mem_rsp_data,
   output logic               a_fifo_wr_en,
   output logic [D_WIDTH-1:0] a_fifo_data,
   input  logic               a_fifo_afull,
   output logic               b_fifo_wr_en,
   output logic [D_WIDTH-1:0] b_fifo_data,
   input  logic               b_fifo_afull,
   output logic               err_orphan
`ifdef AB_FEED_PERF_EN
   ,
   output logic [31:0]        perf_busy_cyc,
   output logic [31:0]        perf_stall_cyc
`endif
);
   localparam int CW = $clog2(OUTST_MAX) + 1;

   fsm_state_e         r_state;
   logic               r_busy, r_done, r_err;
   logic [ADDR_W-1:0]  r_b_base, r_a_ptr, r_b_ptr;
   logic [LEN_W-1:0]   r_a_len, r_b_len, r_a_cnt, r_b_cnt;
   logic [TILE_W-1:0]  r_tiles, r_a_tile, r_b_tile;
   stream_sel_e        r_last_sel, r_hold_sel, w_sel;
   logic               r_hold;
   logic               r_a_wr, r_b_wr;
   logic [D_WIDTH-1:0] r_wdata;

   logic [CW-1:0]      w_outst;
   logic               w_tag_empty, w_tag_dout;
   logic               w_run, w_room, w_elig_a, w_elig_b;
   logic               w_acc, w_rsp_pop, w_start, w_zero_cfg, w_all_issued;

   assign w_run        = (r_state == ST_RUN);
   assign w_room       = (w_outst < CW'(OUTST_MAX));
   assign w_start      = start && !r_busy && (r_state == ST_IDLE);
   assign w_zero_cfg   = (cfg_tiles == '0) || (cfg_a_len == '0) || (cfg_b_len == '0);
   assign w_all_issued = (r_a_tile == r_tiles) && (r_b_tile == r_tiles);

   // A may run at most one tile ahead of B (PE ping-pong A buffer depth)
   assign w_elig_a = w_run && ({1'b0, r_a_tile} <= ({1'b0, r_b_tile} + (TILE_W+1)'(1)))
                     && (r_a_tile < r_tiles) && !a_fifo_afull && w_room;
   assign w_elig_b = w_run && (r_a_tile > r_b_tile) && (r_b_tile < r_tiles)
                     && !b_fifo_afull && w_room;

   always_comb begin
      w_sel = SEL_A;
      if (r_hold)                    w_sel = r_hold_sel;
      else if (w_elig_a && w_elig_b) w_sel = (r_last_sel == SEL_A) ? SEL_B : SEL_A;
      else if (w_elig_b)             w_sel = SEL_B;
   end

   assign mem_req_valid = w_run && (r_hold || w_elig_a || w_elig_b);
   assign mem_req_addr  = (w_sel == SEL_B) ? r_b_ptr : r_a_ptr;
   assign w_acc         = mem_req_valid && mem_req_ready;
   assign w_rsp_pop     = mem_rsp_valid && !w_tag_empty;

   ab_tag_fifo #(.DEPTH(OUTST_MAX)) u_tag (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_acc),
      .i_din   (w_sel),
      .i_pop   (mem_rsp_valid),
      .o_dout  (w_tag_dout),
      .o_empty (w_tag_empty),
      .o_count (w_outst)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (mem_rsp_valid && w_tag_empty) r_err <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               if (w_start) begin
                  r_busy  <= 1'b1;
                  r_err   <= 1'b0;
                  r_state <= w_zero_cfg ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN:   if (w_all_issued) r_state <= ST_DRAIN;
            // wait for the final registered push to leave before signalling done
            ST_DRAIN: if ((w_outst == '0) && !r_a_wr && !r_b_wr) r_state <= ST_DONE;
            default: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_b_base   <= '0;
         r_a_len    <= '0;
         r_b_len    <= '0;
         r_tiles    <= '0;
         r_a_ptr    <= '0;
         r_b_ptr    <= '0;
         r_a_cnt    <= '0;
         r_b_cnt    <= '0;
         r_a_tile   <= '0;
         r_b_tile   <= '0;
         r_last_sel <= SEL_B;
         r_hold     <= 1'b0;
         r_hold_sel <= SEL_A;
         r_a_wr     <= 1'b0;
         r_b_wr     <= 1'b0;
         r_wdata    <= '0;
      end else begin
         if (w_start) begin
            r_b_base   <= cfg_b_base;
            r_a_len    <= cfg_a_len;
            r_b_len    <= cfg_b_len;
            r_tiles    <= cfg_tiles;
            r_a_ptr    <= cfg_a_base;
            r_b_ptr    <= cfg_b_base;
            r_a_cnt    <= '0;
            r_b_cnt    <= '0;
            r_a_tile   <= '0;
            r_b_tile   <= '0;
            r_last_sel <= SEL_B;
         end else if (w_acc) begin
            r_last_sel <= w_sel;
            if (w_sel == SEL_A) begin
               r_a_ptr <= r_a_ptr + ADDR_W'(1);
               if (r_a_cnt == r_a_len - LEN_W'(1)) begin
                  r_a_cnt  <= '0;
                  r_a_tile <= r_a_tile + TILE_W'(1);
               end else begin
                  r_a_cnt <= r_a_cnt + LEN_W'(1);
               end
            end else begin
               if (r_b_cnt == r_b_len - LEN_W'(1)) begin
                  r_b_cnt  <= '0;
                  r_b_ptr  <= r_b_base;
                  r_b_tile <= r_b_tile + TILE_W'(1);
               end else begin
                  r_b_cnt <= r_b_cnt + LEN_W'(1);
                  r_b_ptr <= r_b_ptr + ADDR_W'(1);
               end
            end
         end
         r_hold     <= mem_req_valid && !mem_req_ready;
         r_hold_sel <= w_sel;
         r_a_wr     <= w_rsp_pop && (w_tag_dout == SEL_A);
         r_b_wr     <= w_rsp_pop && (w_tag_dout == SEL_B);
         if (w_rsp_pop) r_wdata <= mem_rsp_data;
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign err_orphan   = r_err;
   assign a_fifo_wr_en = r_a_wr;
   assign b_fifo_wr_en = r_b_wr;
   assign a_fifo_data  = r_wdata;
   assign b_fifo_data  = r_wdata;

`ifdef AB_FEED_PERF_EN
   logic [31:0] r_busy_cyc, r_stall_cyc;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy_cyc  <= '0;
         r_stall_cyc <= '0;
      end else if (w_start) begin
         r_busy_cyc  <= '0;
         r_stall_cyc <= '0;
      end else begin
         if (r_busy && (r_busy_cyc != '1)) r_busy_cyc <= r_busy_cyc + 32'd1;
         if (r_busy && w_run && !w_elig_a && !w_elig_b && (r_stall_cyc != '1))
            r_stall_cyc <= r_stall_cyc + 32'd1;
      end
   end
   assign perf_busy_cyc  = r_busy_cyc;
   assign perf_stall_cyc = r_stall_cyc;
`endif
endmodule
